hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Generates enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three hazard sources:
  - load-use data hazards (stall plus bubble)
  - taken branches/jumps (squash)
  - multi-cycle data-memory accesses (full freeze with timeout)
- Also keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM_WAIT cycles before the error state.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- idex_rd  in  5  rd of instruction in EX
- idex_memread  in  1  EX instruction is a load
- branch_taken  in  1  EX resolved a taken branch/jump
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- clr_cnt  in  1  synchronous clear of performance counters
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to NOP
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- memwb_flush  out  1  MEM/WB clear to NOP
- mem_err  out  1  sticky memory-timeout error
- state  out  2  FSM state (debug)
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  branch squashes

Behaviour:
- FSM states:
  - RUN = 2'd0
  - MEM_WAIT = 2'd1
  - ERROR = 2'd2
- Reset (rst=0, asynchronous):
  - state=RUN; wait counter, stall_cnt, flush_cnt = 0; mem_err=0.
  - While rst=0, all *_en outputs = 0 and all *_flush outputs = 1, overriding everything else.
- Control outputs are combinational from state plus current inputs, so the pipeline registers see them in the same cycle.
- Default (no hazard): all *_en=1, all *_flush=0.
- Priority: ERROR > memory stall > branch flush > load-use stall.
- Memory stall:
  - Condition: state RUN or MEM_WAIT, and mem_req=1, mem_ready=0.
  - pc_en, ifid_en, idex_en, exmem_en, memwb_en all 0; memwb_flush=1 (bubble into WB); other flushes 0.
  - Next state is MEM_WAIT. The wait counter increments each MEM_WAIT cycle.
  - When the wait counter reaches MEM_TIMEOUT-1 with mem_ready still 0: next state ERROR, mem_err set.
- MEM_WAIT exit:
  - mem_ready=1 gives the normal RUN output decode for that cycle (branch/load-use evaluated).
  - Next state RUN; wait counter cleared.
  - In RUN, mem_req=1 with mem_ready=1 in the same cycle causes no stall.
- Branch flush:
  - Condition: branch_taken=1 and no memory stall.
  - ifid_flush=1, idex_flush=1, all enables 1. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
  - flush_cnt increments. During a memory stall branch_taken is held by the frozen pipeline and is not counted until the stall releases.
- Load-use hazard:
  - Condition: idex_memread=1, idex_rd≠0, and ((id_use_rs1 and id_rs1==idex_rd) or (id_use_rs2 and id_rs2==idex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1; idex_en, exmem_en, memwb_en = 1.
  - Exactly one bubble per load, because the next cycle's idex_memread is 0.
- ERROR:
  - All enables 0, all flushes 0, mem_err=1.
  - Held until reset; inputs ignored.
- Counters:
  - stall_cnt increments every cycle pc_en=0 outside reset, including ERROR.
  - Both counters saturate at all-ones.
  - clr_cnt=1 zeroes both next edge and takes priority over increment.
- Reset asserted mid-MEM_WAIT: returns immediately to RUN with outputs as specified for reset; no residual wait count.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; next cycle (memread=0) all en=1; stall_cnt=1.
- x0 and unused operand: idex_rd=0 matching id_rs1, then idex_rd=7 matching id_rs2 with id_use_rs2=0 -> no stall, stall_cnt stays 0.
- Branch plus load-use same cycle: branch_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles all en=0 and memwb_flush=1, state=1; ready cycle all en=1, then state=0; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 -> state=2 and mem_err=1 after 4 stall cycles; stays there under any inputs until rst=0, after which state=0, mem_err=0, counters=0.
- Saturation/clear with CNT_W=4: 20 load-use stalls -> stall_cnt=15; clr_cnt=1 during a stall -> stall_cnt=0 next edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master; the controller is the slave.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       idex_rd;
   logic             idex_memread;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             clr_cnt;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             memwb_en;
   logic             memwb_flush;
   logic             mem_err;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_memread,
             branch_taken, mem_req, mem_ready, clr_cnt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, memwb_flush, mem_err, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_memread,
             branch_taken, mem_req, mem_ready, clr_cnt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, memwb_flush, mem_err, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for a 5-stage RISC-V core: load-use stall,
// branch squash, data-memory freeze with timeout, and stall/flush counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [WAIT_W-1:0] wait_cnt_next;
   logic              mem_err_reg;
   logic              mem_err_next;

   logic load_use;
   logic mem_stall;
   logic branch_flush;

   logic pc_en_c;
   logic ifid_en_c;
   logic ifid_flush_c;
   logic idex_en_c;
   logic idex_flush_c;
   logic exmem_en_c;
   logic memwb_en_c;
   logic memwb_flush_c;

   // Hazard sources; ERROR masks the memory and branch sources entirely.
   always_comb begin
      load_use     = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == hz.idex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == hz.idex_rd)));
      mem_stall    = (state_reg != ERROR) && hz.mem_req && !hz.mem_ready;
      branch_flush = (state_reg != ERROR) && !mem_stall && hz.branch_taken;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= RUN;
         wait_cnt_reg <= '0;
         mem_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         mem_err_reg  <= mem_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      mem_err_next  = mem_err_reg;
      pc_en_c       = 1'b1;
      ifid_en_c     = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_en_c     = 1'b1;
      idex_flush_c  = 1'b0;
      exmem_en_c    = 1'b1;
      memwb_en_c    = 1'b1;
      memwb_flush_c = 1'b0;

      case (state_reg)
         RUN, MEM_WAIT: begin
            if (mem_stall) begin
               pc_en_c       = 1'b0;
               ifid_en_c     = 1'b0;
               idex_en_c     = 1'b0;
               exmem_en_c    = 1'b0;
               memwb_en_c    = 1'b0;
               memwb_flush_c = 1'b1;
               // The wait counter holds the number of stall cycles already spent.
               if (wait_cnt_reg == WAIT_LAST) begin
                  state_next   = ERROR;
                  mem_err_next = 1'b1;
               end else begin
                  state_next    = MEM_WAIT;
                  wait_cnt_next = wait_cnt_reg + 1'b1;
               end
            end else begin
               state_next    = RUN;
               wait_cnt_next = '0;
               if (branch_flush) begin
                  ifid_flush_c = 1'b1;
                  idex_flush_c = 1'b1;
               end else if (load_use) begin
                  pc_en_c      = 1'b0;
                  ifid_en_c    = 1'b0;
                  idex_flush_c = 1'b1;
               end
            end
         end
         ERROR: begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Reset forces every pipeline register to clear, whatever the FSM says.
   always_comb begin
      hz.pc_en       = pc_en_c;
      hz.ifid_en     = ifid_en_c;
      hz.ifid_flush  = ifid_flush_c;
      hz.idex_en     = idex_en_c;
      hz.idex_flush  = idex_flush_c;
      hz.exmem_en    = exmem_en_c;
      hz.memwb_en    = memwb_en_c;
      hz.memwb_flush = memwb_flush_c;
      if (!rst) begin
         hz.pc_en       = 1'b0;
         hz.ifid_en     = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_en     = 1'b0;
         hz.idex_flush  = 1'b1;
         hz.exmem_en    = 1'b0;
         hz.memwb_en    = 1'b0;
         hz.memwb_flush = 1'b1;
      end
   end

   assign hz.mem_err = mem_err_reg;
   assign hz.state   = state_reg;

   // Counter 0 counts frozen-PC cycles, counter 1 counts branch squashes.
   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_reg  [2];
   logic [CNT_W-1:0] cnt_next [2];

   assign cnt_inc[0] = !pc_en_c;
   assign cnt_inc[1] = branch_flush;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (hz.clr_cnt) begin
               cnt_next[gi] = '0;
            end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
               cnt_next[gi] = cnt_reg[gi] + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg[gi] <= '0;
            end else begin
               cnt_reg[gi] <= cnt_next[gi];
            end
         end
      end
   endgenerate

   assign hz.stall_cnt = cnt_reg[0];
   assign hz.flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   hazard_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: consecutive memory-stall cycles, sticky error, counters.
   bit m_err;
   int m_stalls;
   int m_stall_cnt;
   int m_flush_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit model_load_use();
      return hz.idex_memread && (hz.idex_rd != 5'd0) &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.idex_rd) ||
              (hz.id_use_rs2 && hz.id_rs2 == hz.idex_rd));
   endfunction

   function automatic bit model_mem_stall();
      return !m_err && hz.mem_req && !hz.mem_ready;
   endfunction

   function automatic bit model_branch();
      return !m_err && !model_mem_stall() && hz.branch_taken;
   endfunction

   // Expected controls packed as {pc,ifid,ifid_f,idex,idex_f,exmem,memwb,memwb_f}.
   function automatic logic [7:0] model_ctl();
      if (!rst)                   return 8'b0010_1001;
      if (m_err)                  return 8'b0000_0000;
      if (model_mem_stall())      return 8'b0000_0001;
      if (hz.branch_taken)        return 8'b1111_1110;
      if (model_load_use())       return 8'b0001_1110;
      return 8'b1101_0110;
   endfunction

   task automatic compare_all();
      logic [7:0] act;
      int         exp_state;
      act = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
             hz.exmem_en, hz.memwb_en, hz.memwb_flush};
      exp_state = m_err ? 2 : (m_stalls > 0 ? 1 : 0);
      check("ctl", act, model_ctl());
      check("state", hz.state, exp_state);
      check("mem_err", hz.mem_err, m_err);
      check("stall_cnt", hz.stall_cnt, m_stall_cnt);
      check("flush_cnt", hz.flush_cnt, m_flush_cnt);
      $display("cyc %0d rst=%0d ctl=%b state=%0d err=%0d stall=%0d flush=%0d",
               cyc, rst, act, hz.state, hz.mem_err, hz.stall_cnt, hz.flush_cnt);
   endtask

   task automatic model_update();
      bit stall, br, pc_off;
      stall  = model_mem_stall();
      br     = model_branch();
      pc_off = m_err || stall || (!br && model_load_use());
      if (!m_err) begin
         if (stall) begin
            m_stalls++;
            if (m_stalls >= MEM_TIMEOUT) m_err = 1'b1;
         end else begin
            m_stalls = 0;
         end
      end
      if (hz.clr_cnt) begin
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (pc_off && m_stall_cnt < CNT_MAX) m_stall_cnt++;
         if (br && m_flush_cnt < CNT_MAX)     m_flush_cnt++;
      end
   endtask

   task automatic model_reset();
      m_err       = 1'b0;
      m_stalls    = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   // One clock cycle: compare mid-cycle, advance the model at the edge.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      if (rst) model_update();
      cyc++;
      #1;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input bit mr, input bit br, input bit req,
                         input bit rdy, input bit clr);
      hz.id_rs1       = rs1;
      hz.id_rs2       = rs2;
      hz.id_use_rs1   = u1;
      hz.id_use_rs2   = u2;
      hz.idex_rd      = rd;
      hz.idex_memread = mr;
      hz.branch_taken = br;
      hz.mem_req      = req;
      hz.mem_ready    = rdy;
      hz.clr_cnt      = clr;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic randomize_in();
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_pc_en", hz.pc_en, 0);
      check("rst_memwb_flush", hz.memwb_flush, 1);
      step();
      rst = 1'b1;
   endtask

   task automatic clear_counters();
      idle();
      hz.clr_cnt = 1'b1;
      step();
      hz.clr_cnt = 1'b0;
   endtask

   initial begin
      idle();
      model_reset();
      #2;
      do_reset();
      check("reset_stall_cnt", hz.stall_cnt, 0);
      check("reset_state", hz.state, 0);

      // Load-use: one bubble, then free flow.
      set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0);
      #1;
      check("lu_pc_en", hz.pc_en, 0);
      check("lu_idex_flush", hz.idex_flush, 1);
      step();
      idle();
      #1;
      check("lu_after_pc_en", hz.pc_en, 1);
      check("lu_stall_cnt", hz.stall_cnt, 1);
      step();

      // x0 destination and unused operand never stall.
      clear_counters();
      set_in(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 0);
      step();
      set_in(5'd3, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, 0);
      #1;
      check("unused_pc_en", hz.pc_en, 1);
      step();
      check("x0_stall_cnt", hz.stall_cnt, 0);

      // Branch together with load-use: squash wins.
      clear_counters();
      set_in(5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 0);
      #1;
      check("br_pc_en", hz.pc_en, 1);
      check("br_ifid_flush", hz.ifid_flush, 1);
      check("br_idex_flush", hz.idex_flush, 1);
      step();
      idle();
      check("br_flush_cnt", hz.flush_cnt, 1);
      check("br_stall_cnt", hz.stall_cnt, 0);

      // Memory wait of three cycles.
      clear_counters();
      set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
      step();
      check("mw_state", hz.state, 1);
      step();
      step();
      hz.mem_ready = 1'b1;
      #1;
      check("mw_ready_pc_en", hz.pc_en, 1);
      step();
      idle();
      check("mw_exit_state", hz.state, 0);
      check("mw_stall_cnt", hz.stall_cnt, 3);

      // Timeout into ERROR, held until reset.
      set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step();
      check("to_state", hz.state, 2);
      check("to_mem_err", hz.mem_err, 1);
      for (int i = 0; i < 5; i++) begin
         randomize_in();
         hz.clr_cnt = 1'b0;
         step();
      end
      check("err_hold_state", hz.state, 2);
      do_reset();
      idle();
      check("post_rst_state", hz.state, 0);
      check("post_rst_mem_err", hz.mem_err, 0);
      check("post_rst_stall", hz.stall_cnt, 0);
      check("post_rst_flush", hz.flush_cnt, 0);

      // Saturation of stall_cnt, then clear during a stall.
      set_in(5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step();
      check("sat_stall_cnt", hz.stall_cnt, CNT_MAX);
      hz.clr_cnt = 1'b1;
      step();
      hz.clr_cnt = 1'b0;
      check("clr_stall_cnt", hz.stall_cnt, 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         randomize_in();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
